// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared constants and types for the LDPC check-node scheduler.
//   MSG_W    - width of one beta/alpha message (6-bit two's complement)
//   MAG_W    - width of a message magnitude (sign stripped)
//   CN_DEG   - check-node degree (messages per row)
//   PACKED_W - width of one packed row of messages
//   state_e  - scheduler FSM state encoding
package ldpc_pkg;

  localparam int MSG_W    = 6;
  localparam int MAG_W    = MSG_W - 1;
  localparam int CN_DEG   = 4;
  localparam int PACKED_W = MSG_W * CN_DEG;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_EVAL    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/ldpc_cn_scheduler_check_node.sv
// check_node: combinational degree-4 min-sum check-node unit.
//   beta_i  [PACKED_W] - {beta4,beta3,beta2,beta1}, two's complement each
//   alpha_o [PACKED_W] - {alpha4,alpha3,alpha2,alpha1}; each alpha carries the
//                        product of the other three signs and the smallest
//                        magnitude among the other three messages.
module check_node
  import ldpc_pkg::*;
(
  input  logic [PACKED_W-1:0] beta_i,
  output logic [PACKED_W-1:0] alpha_o
);

  logic [CN_DEG-1:0] sgn;
  logic [MAG_W-1:0]  mag     [CN_DEG];
  logic [MAG_W-1:0]  out_mag [CN_DEG];
  logic [MAG_W-1:0]  min1;
  logic [MAG_W-1:0]  min2;
  logic [1:0]        min1_idx;
  logic              sgn_all;

  // Magnitude of the most negative code cannot be represented, so it
  // saturates to the largest positive magnitude.
  always_comb begin
    for (int i = 0; i < CN_DEG; i++) begin
      sgn[i] = beta_i[i*MSG_W + MSG_W-1];
      if (!sgn[i])
        mag[i] = beta_i[i*MSG_W +: MAG_W];
      else if (beta_i[i*MSG_W +: MAG_W] == '0)
        mag[i] = '1;
      else
        mag[i] = (~beta_i[i*MSG_W +: MAG_W]) + MAG_W'(1);
    end
  end

  // Strict less-than keeps the lower index as min1 when magnitudes tie.
  always_comb begin
    min1     = mag[0];
    min1_idx = 2'd0;
    min2     = '1;
    for (int i = 1; i < CN_DEG; i++) begin
      if (mag[i] < min1) begin
        min2     = min1;
        min1     = mag[i];
        min1_idx = 2'(i);
      end else if (mag[i] < min2) begin
        min2 = mag[i];
      end
    end
  end

  assign sgn_all = ^sgn;

  // XOR with the total sign removes each message's own sign contribution.
  always_comb begin
    alpha_o = '0;
    for (int i = 0; i < CN_DEG; i++) begin
      out_mag[i] = (min1_idx == 2'(i)) ? min2 : min1;
      alpha_o[i*MSG_W +: MSG_W] = (sgn_all ^ sgn[i]) ? -{1'b0, out_mag[i]}
                                                     :  {1'b0, out_mag[i]};
    end
  end

endmodule

// File: rtl/ldpc_cn_scheduler.sv
// ldpc_cn_scheduler: iterative decode controller time-sharing one check_node
// across NUM_ROWS parity-check rows of an external message RAM.
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - decode request, honoured only in IDLE
//   busy, done         - activity flag, one-cycle completion pulse
//   parity_ok          - all rows satisfied on the final iteration
//   iter_count         - iterations completed in the current/last decode
//   rd_en/rd_addr      - RAM read request (registered), data returns next cycle
//   rd_data            - packed betas from RAM
//   wr_en/wr_addr/wr_data - RAM write of packed alphas, valid in WRITE only
module ldpc_cn_scheduler
  import ldpc_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int ROW_W    = 3,
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                parity_ok,
  output logic [ITER_W-1:0]   iter_count,
  output logic                rd_en,
  output logic [ROW_W-1:0]    rd_addr,
  input  logic [PACKED_W-1:0] rd_data,
  output logic                wr_en,
  output logic [ROW_W-1:0]    wr_addr,
  output logic [PACKED_W-1:0] wr_data
);

  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_ROWS - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_e              state_q,   state_d;
  logic [ROW_W-1:0]    row_q,     row_d;
  logic [ITER_W-1:0]   iter_q,    iter_d;
  logic                synd_q,    synd_d;
  logic                parity_q,  parity_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                rd_en_q,   rd_en_d;
  logic [ROW_W-1:0]    rd_addr_q, rd_addr_d;
  logic [PACKED_W-1:0] beta_q,    beta_d;
  logic [PACKED_W-1:0] cn_alpha;
  logic [ITER_W-1:0]   iter_inc;
  logic                row_parity;

  check_node u_check_node (
    .beta_i  (beta_q),
    .alpha_o (cn_alpha)
  );

  assign iter_inc = iter_q + ITER_W'(1);

  // Hard-decision parity of the incoming row: XOR of the four sign bits.
  always_comb begin
    row_parity = 1'b0;
    for (int i = 0; i < CN_DEG; i++)
      row_parity = row_parity ^ rd_data[i*MSG_W + MSG_W-1];
  end

  // Next-state logic; rd_en/rd_addr are set on entry to READ so that they
  // are registered and high exactly during the READ cycle.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    iter_d    = iter_q;
    synd_d    = synd_q;
    parity_d  = parity_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    beta_d    = beta_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d     = '0;
          iter_d    = '0;
          synd_d    = 1'b0;
          parity_d  = 1'b0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        beta_d  = rd_data;
        synd_d  = synd_q | row_parity;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = ST_EVAL;
        end else begin
          row_d     = row_q + ROW_W'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = row_q + ROW_W'(1);
          state_d   = ST_READ;
        end
      end
      ST_EVAL: begin
        iter_d = iter_inc;
        if (!synd_q) begin
          parity_d = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else if (iter_inc == ITER_LIMIT) begin
          parity_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          synd_d    = 1'b0;
          rd_en_d   = 1'b1;
          rd_addr_d = row_q;
          state_d   = ST_READ;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      iter_q    <= '0;
      synd_q    <= 1'b0;
      parity_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      beta_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      iter_q    <= iter_d;
      synd_q    <= synd_d;
      parity_q  <= parity_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      beta_q    <= beta_d;
    end
  end

  // Write port is decoded from the state so an asynchronous reset kills an
  // in-flight write immediately.
  assign wr_en      = (state_q == ST_WRITE);
  assign wr_addr    = wr_en ? row_q    : '0;
  assign wr_data    = wr_en ? cn_alpha : '0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_ok  = parity_q;
  assign iter_count = iter_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_ldpc_cn_scheduler.sv
// tb_ldpc_cn_scheduler: directed self-checking bench for ldpc_cn_scheduler
// with NUM_ROWS=2, MAX_ITER=4 and a two-row message RAM model.
module tb_ldpc_cn_scheduler;

  localparam int NR = 2;
  localparam int RW = 1;
  localparam int MI = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          parity_ok;
  logic [IW-1:0] iter_count;
  logic          rd_en;
  logic [RW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic          wr_en;
  logic [RW-1:0] wr_addr;
  logic [23:0]   wr_data;

  logic [23:0] mem    [NR];
  logic [23:0] lastWr [NR];
  int          wrCount [NR] = '{default: 0};
  int          rdCount      = 0;
  int          overlapCount = 0;
  int          testCount    = 0;
  int          failCount    = 0;

  always #5 clk = ~clk;

  ldpc_cn_scheduler #(
    .NUM_ROWS (NR),
    .ROW_W    (RW),
    .MAX_ITER (MI),
    .ITER_W   (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .parity_ok  (parity_ok),
    .iter_count (iter_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Message RAM model: one-cycle read latency, write log per row.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rdCount <= rdCount + 1;
    end
    if (wr_en) begin
      lastWr[wr_addr]  <= wr_data;
      wrCount[wr_addr] <= wrCount[wr_addr] + 1;
    end
    if (rd_en && wr_en)
      overlapCount <= overlapCount + 1;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] pack(input logic [5:0] m4, input logic [5:0] m3,
                                       input logic [5:0] m2, input logic [5:0] m1);
    return {m4, m3, m2, m1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s);
    start = s;
    tick();
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for done; n is the cycle index after the start cycle, bc counts
  // busy-high samples from cycle n0 onward.
  task automatic waitDone(input int n0, output int n, output int bc);
    n  = n0;
    bc = busy ? 1 : 0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (busy) bc++;
    end
  endtask

  logic [23:0] p1, p2row0, tieRow, negRow;
  int n, bc, w0, w1, rc0, k;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    p1     = pack(6'h1F, 6'h18, 6'h10, 6'h08);
    p2row0 = pack(6'h1F, 6'h18, 6'h10, 6'h38);
    tieRow = pack(6'h18, 6'h10, 6'h08, 6'h08);
    negRow = pack(6'h09, 6'h05, 6'h3B, 6'h3F);
    mem[0] = p1;
    mem[1] = p1;
    repeat (3) tick();

    checkOutput("reset_busy",      busy,       0);
    checkOutput("reset_done",      done,       0);
    checkOutput("reset_parity",    parity_ok,  0);
    checkOutput("reset_rd_en",     rd_en,      0);
    checkOutput("reset_wr_en",     wr_en,      0);
    checkOutput("reset_iter",      iter_count, 0);
    checkOutput("reset_rd_addr",   rd_addr,    0);
    checkOutput("reset_wr_addr",   wr_addr,    0);
    checkOutput("reset_wr_data",   wr_data,    0);
    rst_n = 1'b1;
    tick();

    // Clean codeword: one iteration, both rows written once.
    w0 = wrCount[0];
    w1 = wrCount[1];
    applyStimulus(1'b1);
    checkOutput("t1_busy_start", busy, 1);
    checkOutput("t1_rd_en_start", rd_en, 1);
    waitDone(1, n, bc);
    checkOutput("t1_done_cycle",  n,          8);
    checkOutput("t1_parity",      parity_ok,  1);
    checkOutput("t1_iter",        iter_count, 1);
    checkOutput("t1_busy_cycles", bc,         8);
    checkOutput("t1_wr_row0",     lastWr[0],  pack(6'h08, 6'h08, 6'h08, 6'h10));
    checkOutput("t1_wr_row1",     lastWr[1],  pack(6'h08, 6'h08, 6'h08, 6'h10));
    checkOutput("t1_wrcnt_row0",  wrCount[0] - w0, 1);
    checkOutput("t1_wrcnt_row1",  wrCount[1] - w1, 1);
    tick();
    checkOutput("t1_busy_after",  busy,       0);
    checkOutput("t1_done_after",  done,       0);
    checkOutput("t1_iter_held",   iter_count, 1);

    // Row 0 never satisfies parity: runs to the iteration limit.
    mem[0] = p2row0;
    w0 = wrCount[0];
    applyStimulus(1'b1);
    waitDone(1, n, bc);
    checkOutput("t2_done_cycle", n,          29);
    checkOutput("t2_parity",     parity_ok,  0);
    checkOutput("t2_iter",       iter_count, 4);
    checkOutput("t2_busy_cycles", bc,        29);
    checkOutput("t2_wr_row0",    lastWr[0],  pack(6'h38, 6'h38, 6'h38, 6'h10));
    checkOutput("t2_wrcnt_row0", wrCount[0] - w0, 4);
    tick();

    // Magnitude tie in row 0, mixed negative messages in row 1.
    mem[0] = tieRow;
    mem[1] = negRow;
    applyStimulus(1'b1);
    waitDone(1, n, bc);
    checkOutput("t3_done_cycle", n,         8);
    checkOutput("t3_parity",     parity_ok, 1);
    checkOutput("t3_wr_tie",     lastWr[0], pack(6'h08, 6'h08, 6'h08, 6'h08));
    checkOutput("t3_wr_neg",     lastWr[1], pack(6'h01, 6'h01, 6'h3F, 6'h3B));
    tick();

    // start pulses during READ and during DONE must be ignored.
    mem[0] = p1;
    mem[1] = p1;
    rc0 = rdCount;
    applyStimulus(1'b1);
    checkOutput("t4_in_read", rd_en, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(2, n, bc);
    checkOutput("t4_done_cycle",  n,  8);
    checkOutput("t4_busy_cycles", bc, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t4_busy_idle", busy, 0);
    repeat (5) tick();
    checkOutput("t4_reads",      rdCount - rc0, 2);
    checkOutput("t4_still_idle", busy,          0);

    // Back-to-back: start in the cycle after DONE.
    applyStimulus(1'b1);
    waitDone(1, n, bc);
    checkOutput("t5_first_done", n, 8);
    tick();
    checkOutput("t5_parity_held", parity_ok, 1);
    applyStimulus(1'b1);
    checkOutput("t5_parity_clear", parity_ok, 0);
    checkOutput("t5_busy_restart", busy,      1);
    waitDone(1, n, bc);
    checkOutput("t5_second_done", n,         8);
    checkOutput("t5_parity",      parity_ok, 1);
    tick();

    // Asynchronous reset during the WRITE of row 1.
    applyStimulus(1'b1);
    k = 0;
    while (!(wr_en && wr_addr == 1'b1) && k < 20) begin
      tick();
      k++;
    end
    checkOutput("t6_reach_write1", wr_en, 1);
    w1 = wrCount[1];
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy",    busy,       0);
    checkOutput("t6_rst_wr_en",   wr_en,      0);
    checkOutput("t6_rst_rd_en",   rd_en,      0);
    checkOutput("t6_rst_wr_data", wr_data,    0);
    checkOutput("t6_rst_iter",    iter_count, 0);
    checkOutput("t6_rst_done",    done,       0);
    tick();
    checkOutput("t6_no_write", wrCount[1] - w1, 0);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1);
    checkOutput("t6_restart_rd_en",   rd_en,      1);
    checkOutput("t6_restart_rd_addr", rd_addr,    0);
    checkOutput("t6_restart_iter",    iter_count, 0);
    waitDone(1, n, bc);
    checkOutput("t6_done_cycle", n,          8);
    checkOutput("t6_iter",       iter_count, 1);
    tick();

    checkOutput("rd_wr_overlap", overlapCount, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
